// File: rtl/mem_responder.sv
// IMEM/DMEM responder for the pipelined core, with a byte-serial loader that holds the core while filling.
// Optional build macro MEM_BYPASS_EN: write-first forwarding of main_m_data onto main_m_q during core writes.
module mem_responder #(
  parameter int AW = 12,
  parameter int DW = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [AW-1:0] ir_m_addr,
  output logic [DW-1:0] ir_m_q,
  input  logic [AW-1:0] main_m_addr,
  input  logic [DW-1:0] main_m_data,
  input  logic          main_m_rw,
  output logic [DW-1:0] main_m_q,
  input  logic          ld_start,
  input  logic          ld_sel,
  input  logic [AW:0]   ld_len,
  input  logic          ld_valid,
  input  logic [7:0]    ld_byte,
  output logic          ld_ready,
  output logic          ld_busy,
  output logic          ld_done,
  output logic          hold
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HI   = 3'd1;
  localparam logic [2:0] S_LO   = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [AW:0] MAX_LEN = {1'b1, {AW{1'b0}}};

  logic [DW-1:0] imem [2**AW];
  logic [DW-1:0] dmem [2**AW];

  logic [2:0]    state;
  logic          sel;
  logic [AW:0]   len;
  logic [AW:0]   cnt;
  logic [AW:0]   cnt_next;
  logic [AW:0]   len_clamped;
  logic [AW-1:0] ptr;
  logic [7:0]    hi;
  logic [7:0]    lo;
  logic          byte_xfer;
  logic          core_we;
  logic          ld_we;

  assign ld_ready    = (state == S_HI) || (state == S_LO);
  assign ld_busy     = ld_ready || (state == S_WR);
  assign hold        = ld_busy;
  assign ld_done     = (state == S_DONE);
  assign byte_xfer   = ld_valid && ld_ready;
  assign core_we     = main_m_rw && ((state == S_IDLE) || (state == S_DONE));
  assign ld_we       = (state == S_WR) && !reset;
  assign cnt_next    = cnt + (AW+1)'(1);
  assign len_clamped = (ld_len > MAX_LEN) ? MAX_LEN : ld_len;

  assign ir_m_q = imem[ir_m_addr];

`ifdef MEM_BYPASS_EN
  assign main_m_q = core_we ? main_m_data : dmem[main_m_addr];
`else
  assign main_m_q = dmem[main_m_addr];
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
      sel   <= 1'b0;
      len   <= '0;
      cnt   <= '0;
      ptr   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ld_start) begin
            sel   <= ld_sel;
            len   <= len_clamped;
            ptr   <= '0;
            cnt   <= '0;
            state <= (len_clamped == '0) ? S_DONE : S_HI;
          end
        end
        S_HI: begin
          if (byte_xfer) begin
            hi    <= ld_byte;
            state <= S_LO;
          end
        end
        S_LO: begin
          if (byte_xfer) begin
            lo    <= ld_byte;
            state <= S_WR;
          end
        end
        // ptr is AW bits wide so a full-depth load wraps it back to 0 after the last word.
        S_WR: begin
          ptr   <= ptr + AW'(1);
          cnt   <= cnt_next;
          state <= (cnt_next == len) ? S_DONE : S_HI;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Array contents survive reset; only the loader and the core data port write them.
  always_ff @(posedge clock) begin
    if (ld_we && !sel) imem[ptr] <= {hi, lo};
  end

  always_ff @(posedge clock) begin
    if (ld_we && sel)  dmem[ptr] <= {hi, lo};
    else if (core_we)  dmem[main_m_addr] <= main_m_data;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: randomized loads and core writes against a word-level memory model.
module tb_mem_responder;
  localparam int AW    = 12;
  localparam int DW    = 16;
  localparam int DEPTH = 4096;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] ir_m_addr = '0;
  logic [DW-1:0] ir_m_q;
  logic [AW-1:0] main_m_addr = '0;
  logic [DW-1:0] main_m_data = '0;
  logic          main_m_rw = 1'b0;
  logic [DW-1:0] main_m_q;
  logic          ld_start = 1'b0;
  logic          ld_sel = 1'b0;
  logic [AW:0]   ld_len = '0;
  logic          ld_valid = 1'b0;
  logic [7:0]    ld_byte = '0;
  logic          ld_ready;
  logic          ld_busy;
  logic          ld_done;
  logic          hold;

  int checks = 0;
  int errors = 0;

  logic [15:0] imem_m [DEPTH];
  logic [15:0] dmem_m [DEPTH];
  bit          dmem_k [DEPTH];
  logic [7:0]  stream [2*DEPTH];
  bit          intrude = 1'b0;

  mem_responder #(.AW(AW), .DW(DW)) dut (
    .clock(clock), .reset(reset),
    .ir_m_addr(ir_m_addr), .ir_m_q(ir_m_q),
    .main_m_addr(main_m_addr), .main_m_data(main_m_data),
    .main_m_rw(main_m_rw), .main_m_q(main_m_q),
    .ld_start(ld_start), .ld_sel(ld_sel), .ld_len(ld_len),
    .ld_valid(ld_valid), .ld_byte(ld_byte),
    .ld_ready(ld_ready), .ld_busy(ld_busy), .ld_done(ld_done), .hold(hold)
  );

  always #5 clock = ~clock;

  // Drives one load and tracks it as a byte stream: two accepted bytes, then one write cycle per word.
  task automatic do_load(input bit sel, input logic [AW:0] len_in, input bit rnd_valid, input int abort_words);
    int n, bi, phase, words, cyc;
    bit exp_ready;
    n = (len_in > 13'd4096) ? DEPTH : int'(len_in);
    @(negedge clock);
    ld_start = 1'b1; ld_sel = sel; ld_len = len_in; main_m_rw = 1'b0;
    @(negedge clock);
    ld_start = 1'b0;
    if (n == 0) begin
      checks++;
      if ({ld_done, ld_busy, hold, ld_ready} !== 4'b1000) begin
        errors++; $display("[TB] FAIL zero_len_done got %b want 1000", {ld_done, ld_busy, hold, ld_ready});
      end
      @(negedge clock);
      checks++;
      if ({ld_done, ld_busy, hold, ld_ready} !== 4'b0000) begin
        errors++; $display("[TB] FAIL zero_len_idle got %b want 0000", {ld_done, ld_busy, hold, ld_ready});
      end
      return;
    end
    bi = 0; phase = 0; words = 0; cyc = 0;
    while (words < n && cyc < 20 * n + 100) begin
      if (abort_words > 0 && words == abort_words && phase == 1) begin
        reset = 1'b1; ld_valid = 1'b0;
        @(negedge clock);
        checks++;
        if ({ld_done, ld_busy, hold, ld_ready} !== 4'b0000) begin
          errors++; $display("[TB] FAIL abort_idle got %b want 0000", {ld_done, ld_busy, hold, ld_ready});
        end
        reset = 1'b0;
        return;
      end
      exp_ready = (phase != 2);
      checks++;
      if ({ld_busy, hold, ld_done, ld_ready} !== {1'b1, 1'b1, 1'b0, exp_ready}) begin
        errors++;
        $display("[TB] FAIL load_status cyc %0d got %b want %b", cyc, {ld_busy, hold, ld_done, ld_ready},
                 {1'b1, 1'b1, 1'b0, exp_ready});
      end
      main_m_rw = intrude; main_m_addr = 12'd5; main_m_data = 16'hAAAA;
      ld_start = intrude ? 1'($urandom_range(0, 1)) : 1'b0;
      ld_len = 13'd3; ld_sel = ~sel;
      if (phase == 2) begin
        if (sel) begin
          dmem_m[words % DEPTH] = {stream[bi-2], stream[bi-1]};
          dmem_k[words % DEPTH] = 1'b1;
        end else begin
          imem_m[words % DEPTH] = {stream[bi-2], stream[bi-1]};
        end
        words++; phase = 0; ld_valid = 1'b0;
      end else begin
        ld_valid = rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1;
        ld_byte = stream[bi];
        if (ld_valid) begin bi++; phase++; end
      end
      @(negedge clock);
      cyc++;
    end
    main_m_rw = 1'b0; ld_start = 1'b0; ld_valid = 1'b0;
    checks++;
    if (words != n) begin
      errors++; $display("[TB] FAIL load_timeout got %0d words want %0d", words, n);
    end
    checks++;
    if ({ld_done, ld_busy, hold, ld_ready} !== 4'b1000) begin
      errors++; $display("[TB] FAIL load_done got %b want 1000", {ld_done, ld_busy, hold, ld_ready});
    end
    if (!rnd_valid) begin
      checks++;
      if (cyc != 3 * n) begin
        errors++; $display("[TB] FAIL load_cycles got %0d want %0d", cyc, 3 * n);
      end
    end
    @(negedge clock);
    checks++;
    if ({ld_done, ld_busy, hold, ld_ready} !== 4'b0000) begin
      errors++; $display("[TB] FAIL done_single_pulse got %b want 0000", {ld_done, ld_busy, hold, ld_ready});
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if ({ld_ready, ld_busy, ld_done, hold} !== 4'b0000) begin
      errors++; $display("[TB] FAIL reset_outputs got %b want 0000", {ld_ready, ld_busy, ld_done, hold});
    end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if ({ld_ready, ld_busy, ld_done, hold} !== 4'b0000) begin
      errors++; $display("[TB] FAIL post_reset_idle got %b want 0000", {ld_ready, ld_busy, ld_done, hold});
    end
  endtask

  task automatic test_core_write;
    logic [15:0] exp, d;
    logic [11:0] a;
    main_m_addr = 12'h010; main_m_data = 16'h1111; main_m_rw = 1'b1;
    @(negedge clock);
    main_m_data = 16'hBEEF;
    #1;
`ifdef MEM_BYPASS_EN
    exp = 16'hBEEF;
`else
    exp = 16'h1111;
`endif
    checks++;
    if (main_m_q !== exp) begin
      errors++; $display("[TB] FAIL write_cycle_q got %h want %h", main_m_q, exp);
    end
    @(negedge clock);
    main_m_rw = 1'b0;
    #1;
    checks++;
    if (main_m_q !== 16'hBEEF) begin
      errors++; $display("[TB] FAIL write_visible got %h want BEEF", main_m_q);
    end
    dmem_m[16] = 16'hBEEF; dmem_k[16] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      a = (i < 2) ? 12'h010 : 12'($urandom_range(0, DEPTH - 1));
      d = 16'($urandom);
      @(negedge clock);
      main_m_addr = a; main_m_data = d; main_m_rw = 1'b1;
      #1;
`ifdef MEM_BYPASS_EN
      checks++;
      if (main_m_q !== d) begin
        errors++; $display("[TB] FAIL bypass_q got %h want %h", main_m_q, d);
      end
`else
      if (dmem_k[a]) begin
        checks++;
        if (main_m_q !== dmem_m[a]) begin
          errors++; $display("[TB] FAIL read_first_q got %h want %h", main_m_q, dmem_m[a]);
        end
      end
`endif
      @(negedge clock);
      main_m_rw = 1'b0;
      dmem_m[a] = d; dmem_k[a] = 1'b1;
      #1;
      checks++;
      if (main_m_q !== d) begin
        errors++; $display("[TB] FAIL rand_write got %h want %h", main_m_q, d);
      end
    end
  endtask

  task automatic test_imem_load;
    stream[0] = 8'h12; stream[1] = 8'h34; stream[2] = 8'h56; stream[3] = 8'h78;
    do_load(1'b0, 13'd2, 1'b0, 0);
    ir_m_addr = 12'd0;
    #1;
    checks++;
    if (ir_m_q !== 16'h1234) begin
      errors++; $display("[TB] FAIL imem_word0 got %h want 1234", ir_m_q);
    end
    ir_m_addr = 12'd1;
    #1;
    checks++;
    if (ir_m_q !== 16'h5678) begin
      errors++; $display("[TB] FAIL imem_word1 got %h want 5678", ir_m_q);
    end
  endtask

  task automatic test_backpressure;
    bit s;
    int len;
    for (int t = 0; t < 4; t++) begin
      s = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 6);
      for (int i = 0; i < 2 * len; i++) stream[i] = 8'($urandom);
      do_load(s, 13'(len), 1'b1, 0);
      for (int i = 0; i < len; i++) begin
        main_m_addr = 12'(i); ir_m_addr = 12'(i);
        #1;
        checks++;
        if ((s ? main_m_q : ir_m_q) !== (s ? dmem_m[i] : imem_m[i])) begin
          errors++;
          $display("[TB] FAIL backpressure_word %0d got %h want %h", i, s ? main_m_q : ir_m_q,
                   s ? dmem_m[i] : imem_m[i]);
        end
      end
    end
  endtask

  task automatic test_write_during_load;
    for (int i = 0; i < 16; i++) stream[i] = 8'($urandom);
    intrude = 1'b1;
    do_load(1'b1, 13'd8, 1'b1, 0);
    intrude = 1'b0;
    for (int i = 0; i < 8; i++) begin
      main_m_addr = 12'(i);
      #1;
      checks++;
      if (main_m_q !== dmem_m[i]) begin
        errors++; $display("[TB] FAIL intrude_word %0d got %h want %h", i, main_m_q, dmem_m[i]);
      end
    end
  endtask

  task automatic test_zero_len;
    do_load(1'b1, 13'd0, 1'b0, 0);
    main_m_addr = 12'd0;
    #1;
    checks++;
    if (main_m_q !== dmem_m[0]) begin
      errors++; $display("[TB] FAIL zero_len_nowrite got %h want %h", main_m_q, dmem_m[0]);
    end
  endtask

  task automatic test_clamp;
    for (int i = 0; i < 2 * DEPTH; i++) stream[i] = 8'($urandom);
    do_load(1'b1, 13'h1FFF, 1'b0, 0);
    for (int i = 0; i < DEPTH; i++) begin
      main_m_addr = 12'(i);
      #1;
      checks++;
      if (main_m_q !== dmem_m[i]) begin
        errors++; $display("[TB] FAIL clamp_word %0d got %h want %h", i, main_m_q, dmem_m[i]);
      end
    end
  endtask

  task automatic test_reset_abort;
    for (int i = 0; i < 10; i++) stream[i] = 8'($urandom);
    do_load(1'b1, 13'd5, 1'b0, 3);
    for (int i = 0; i < 5; i++) begin
      main_m_addr = 12'(i);
      #1;
      checks++;
      if (main_m_q !== dmem_m[i]) begin
        errors++; $display("[TB] FAIL abort_word %0d got %h want %h", i, main_m_q, dmem_m[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    for (int t = 0; t < 2; t++) begin
      for (int i = 0; i < 6; i++) stream[i] = 8'($urandom);
      do_load(1'b0, 13'd3, 1'(t), 0);
      for (int i = 0; i < 3; i++) begin
        ir_m_addr = 12'(i);
        #1;
        checks++;
        if (ir_m_q !== imem_m[i]) begin
          errors++; $display("[TB] FAIL b2b_word %0d got %h want %h", i, ir_m_q, imem_m[i]);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) dmem_k[i] = 1'b0;
    test_reset();
    test_core_write();
    test_imem_load();
    test_backpressure();
    test_write_during_load();
    test_clamp();
    test_zero_len();
    test_reset_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
